horner_seq_ctrl: RTL and testbench
==================================

Name: horner_seq_ctrl

Overview:
Parametrised sequencing controller for the NLA polynomial datapath. It evaluates p(x) = sum c_k * x^k by Horner's rule, one multiply-then-add pass per coefficient, highest coefficient first. The multiplier and adder latencies are configurable. The coefficient set is latched once and reused for every sample drained from the signal buffer, and results are returned over a valid/ready handshake. It sits between the signal/coeff buffers and the add/mul/result registers and generates their load strobes.

Parameters:
ADDR_LINES, 4, coefficient buffer address width; max coefficients = 2^ADDR_LINES
MUL_LAT, 1, multiplier latency in cycles (>=1)
ADD_LAT, 1, adder latency in cycles (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_coeff  input  1  level; coefficient buffer fully written
coeff_cnt  input  ADDR_LINES+1  number of coefficients written (valid range 1..2^ADDR_LINES)
coeff_reload  input  1  pulse; discard coefficient set, refill
sig_empty  input  1  signal buffer empty
flush  input  1  synchronous abort of in-flight sample
result_ready  input  1  downstream accepts result
rst_reg_n  output  1  registered datapath reset
wr_en_coeff  output  1  coefficient buffer write enable
rd_en_signal  output  1  pop one sample from signal buffer
rd_en_coeff  output  1  coefficient read strobe
coeff_rd_addr  output  ADDR_LINES  coefficient read address
LD_signal  output  1  load multiplier operands (acc, x)
LD_coeff  output  1  load adder operands (product, c_k)
LD_result  output  1  capture accumulator into result register
redo  output  1  clear accumulator
result_valid  output  1  result register holds unconsumed result
busy  output  1  high in any state other than IDLE/WAIT_X
cfg_err  output  1  one-cycle pulse on invalid coeff_cnt

Behaviour:
- Reset: state IDLE. All outputs 0. rst_reg_n 0 during reset, 1 from the first clk edge after release. Internal deg/idx/coeff_valid cleared.
- IDLE: wr_en_coeff = !start_coeff.
  - start_coeff=1 and 1<=coeff_cnt<=2^ADDR_LINES: latch deg = coeff_cnt-1, set coeff_valid, go to WAIT_X.
  - start_coeff=1 with an invalid count: cfg_err pulses one cycle, stay in IDLE.
- WAIT_X:
  - coeff_reload has priority: clear coeff_valid, go to IDLE.
  - Else if !sig_empty: assert rd_en_signal and redo, set idx = deg, go to FETCH_X.
- FETCH_X (1 cycle): coeff_rd_addr = idx, rd_en_coeff = 1, LD_signal = 1, go to MUL_WAIT.
- MUL_WAIT (MUL_LAT cycles): then go to FETCH_C.
- FETCH_C (1 cycle): LD_coeff = 1, go to ADD_WAIT.
- ADD_WAIT (ADD_LAT cycles): on the last cycle:
  - idx==0: go to RESULT.
  - Else: idx decrements, go to FETCH_X.
- RESULT:
  - Entry cycle: LD_result = 1.
  - result_valid = 1 from the cycle after entry and held until result_valid & result_ready.
  - On the handshake: result_valid drops next cycle, go to WAIT_X.
  - result_ready already high on the first valid cycle gives a one-cycle handshake.
- Latency: if rd_en_signal is asserted in cycle t, LD_result is asserted in cycle t+1+(deg+1)*(2+MUL_LAT+ADD_LAT).
- Throughput: back-to-back samples; coefficients are reused with no refill.
- coeff_rd_addr holds its last value outside FETCH_X. It walks deg..0 and never wraps; deg=2^ADDR_LINES-1 is legal.
- flush: from any state except IDLE, go to WAIT_X next cycle. Clears result_valid and the in-flight sample, keeps coeff_valid and deg. Ignored in IDLE. If flush and result_ready arrive together, flush wins.
- Asynchronous reset mid-operation aborts immediately to the reset values. The coefficient set must be reloaded.
- sig_empty is sampled only in WAIT_X. No pop ever occurs while sig_empty=1.

Optional Feature:
NLA_PERF_CNT_EN: adds outputs samples_done[15:0] and stall_cycles[15:0].
- samples_done increments on each result handshake.
- stall_cycles increments on each cycle with result_valid & !result_ready.
- Both counters saturate at 16'hFFFF and clear on reset or coeff_reload.
- Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package nla_ctrl_pkg holds the state encoding constants (IDLE, WAIT_X, FETCH_X, MUL_WAIT, FETCH_C, ADD_WAIT, RESULT) and LAT_W = $clog2(max(MUL_LAT,ADD_LAT))+1.
- One sub-module, lat_timer: a loadable down-counter that raises done on its last count. It is reused for MUL_WAIT and ADD_WAIT.

Test Plan:
- Reset, then coeff_cnt=3, start_coeff=1, one sample (MUL_LAT=ADD_LAT=1) -> rd_en_signal at t, coeff_rd_addr 2,1,0 in FETCH_X, LD_result at t+13, result_valid at t+14.
- coeff_cnt=0 or 17 (ADDR_LINES=4) with start_coeff=1 -> cfg_err single pulse, stays IDLE, wr_en_coeff=0; coeff_cnt=16 -> deg=15, addresses 15..0.
- Three queued samples, result_ready=1 -> three results, coefficients not refilled, wr_en_coeff stays 0.
- result_ready low 5 cycles -> result_valid held, no new pop until handshake (stall_cycles=5 with NLA_PERF_CNT_EN).
- flush asserted in MUL_WAIT -> WAIT_X next cycle, no LD_result; next sample evaluates correctly with the same coefficients.
- MUL_LAT=3, ADD_LAT=2, coeff_cnt=1 -> LD_result at t+8; coeff_reload in WAIT_X -> IDLE, wr_en_coeff=1.

Source files
------------

// File: rtl/nla_ctrl_pkg.sv
// Shared types for the NLA polynomial sequencing controller.
// State encoding and latency-timer width helper.
package nla_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    FETCH_X,
    MUL_WAIT,
    FETCH_C,
    ADD_WAIT,
    RESULT
  } state_e;

  localparam int PERF_W = 16;

  // LAT_W = $clog2(max(MUL_LAT, ADD_LAT)) + 1
  function automatic int lat_w(input int mul_lat, input int add_lat);
    int m;
    m = (mul_lat > add_lat) ? mul_lat : add_lat;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/horner_seq_ctrl_lat_timer.sv
// Loadable down-counter; done is high on the last count.
// Shared by the multiply and add wait phases.
module lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/horner_seq_ctrl.sv
// Horner-rule sequencer for the NLA polynomial datapath.
// Optional perf counters: define NLA_PERF_CNT_EN.
module horner_seq_ctrl
  import nla_ctrl_pkg::*;
#(
  parameter int ADDR_LINES = 4,
  parameter int MUL_LAT    = 1,
  parameter int ADD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_coeff,
  input  logic [ADDR_LINES:0]   coeff_cnt,
  input  logic                  coeff_reload,
  input  logic                  sig_empty,
  input  logic                  flush,
  input  logic                  result_ready,
  output logic                  rst_reg_n,
  output logic                  wr_en_coeff,
  output logic                  rd_en_signal,
  output logic                  rd_en_coeff,
  output logic [ADDR_LINES-1:0] coeff_rd_addr,
  output logic                  LD_signal,
  output logic                  LD_coeff,
  output logic                  LD_result,
  output logic                  redo,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  cfg_err
`ifdef NLA_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     samples_done,
  output logic [PERF_W-1:0]     stall_cycles
`endif
);

  localparam int LAT_W = lat_w(MUL_LAT, ADD_LAT);
  localparam logic [ADDR_LINES:0] MAX_CNT =
    (ADDR_LINES+1)'(1) << ADDR_LINES;

  state_e state_q, state_d;
  logic [ADDR_LINES-1:0] deg_q, deg_d;
  logic [ADDR_LINES-1:0] idx_q, idx_d;
  logic [ADDR_LINES-1:0] addr_q, addr_d;
  logic [ADDR_LINES:0]   cnt_m1;
  logic cv_q, cv_d;
  logic rv_q, rv_d;
  logic bad_q, bad_d;
  logic cfg_err_q, cfg_err_d;
  logic rst_reg_q, rst_reg_d;
  logic tmr_load;
  logic [LAT_W-1:0] tmr_val;
  logic tmr_done;

  lat_timer #(
    .W (LAT_W)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign cnt_m1 = coeff_cnt - (ADDR_LINES+1)'(1);

  always_comb begin
    state_d      = state_q;
    deg_d        = deg_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    cv_d         = cv_q;
    rv_d         = rv_q;
    bad_d        = 1'b0;
    rst_reg_d    = 1'b1;
    tmr_load     = 1'b0;
    tmr_val      = LAT_W'(ADD_LAT - 1);
    wr_en_coeff  = 1'b0;
    rd_en_signal = 1'b0;
    rd_en_coeff  = 1'b0;
    LD_signal    = 1'b0;
    LD_coeff     = 1'b0;
    LD_result    = 1'b0;
    redo         = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_en_coeff = rst_reg_q & !start_coeff;
        if (start_coeff) begin
          if (coeff_cnt != '0 && coeff_cnt <= MAX_CNT) begin
            deg_d   = cnt_m1[ADDR_LINES-1:0];
            cv_d    = 1'b1;
            state_d = WAIT_X;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      WAIT_X: begin
        if (coeff_reload) begin
          cv_d    = 1'b0;
          state_d = IDLE;
        end else if (!sig_empty && cv_q) begin
          rd_en_signal = 1'b1;
          redo         = 1'b1;
          idx_d        = deg_q;
          state_d      = FETCH_X;
        end
      end
      FETCH_X: begin
        rd_en_coeff = 1'b1;
        LD_signal   = 1'b1;
        addr_d      = idx_q;
        tmr_load    = 1'b1;
        tmr_val     = LAT_W'(MUL_LAT - 1);
        state_d     = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (tmr_done) state_d = FETCH_C;
      end
      FETCH_C: begin
        LD_coeff = 1'b1;
        tmr_load = 1'b1;
        state_d  = ADD_WAIT;
      end
      ADD_WAIT: begin
        if (tmr_done) begin
          if (idx_q == '0) begin
            state_d = RESULT;
          end else begin
            idx_d   = idx_q - ADDR_LINES'(1);
            state_d = FETCH_X;
          end
        end
      end
      RESULT: begin
        LD_result = !rv_q;
        rv_d      = 1'b1;
        if (rv_q && result_ready) begin
          rv_d    = 1'b0;
          state_d = WAIT_X;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort keeps the coefficient set; no pop or capture this cycle.
    if (flush && state_q != IDLE) begin
      state_d      = WAIT_X;
      rv_d         = 1'b0;
      cv_d         = cv_q;
      deg_d        = deg_q;
      rd_en_signal = 1'b0;
      redo         = 1'b0;
      LD_result    = 1'b0;
    end
    cfg_err_d = bad_d & !bad_q;
  end

  assign coeff_rd_addr = (state_q == FETCH_X) ? idx_q : addr_q;
  assign result_valid  = rv_q;
  assign busy          = (state_q != IDLE) && (state_q != WAIT_X);
  assign cfg_err       = cfg_err_q;
  assign rst_reg_n     = rst_reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      deg_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      cv_q      <= 1'b0;
      rv_q      <= 1'b0;
      bad_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      rst_reg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deg_q     <= deg_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      cv_q      <= cv_d;
      rv_q      <= rv_d;
      bad_q     <= bad_d;
      cfg_err_q <= cfg_err_d;
      rst_reg_q <= rst_reg_d;
    end
  end

`ifdef NLA_PERF_CNT_EN
  logic [PERF_W-1:0] sd_q, sd_d;
  logic [PERF_W-1:0] sc_q, sc_d;
  logic hs;

  assign hs = (state_q == RESULT) & rv_q & result_ready & !flush;

  always_comb begin
    sd_d = sd_q;
    sc_d = sc_q;
    if (coeff_reload) begin
      sd_d = '0;
      sc_d = '0;
    end else begin
      if (hs && sd_q != '1) sd_d = sd_q + PERF_W'(1);
      if (rv_q && !result_ready && sc_q != '1) begin
        sc_d = sc_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_q <= '0;
      sc_q <= '0;
    end else begin
      sd_q <= sd_d;
      sc_q <= sc_d;
    end
  end

  assign samples_done = sd_q;
  assign stall_cycles = sc_q;
`endif

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// Directed self-checking bench for horner_seq_ctrl.
// Second instance covers MUL_LAT=3, ADD_LAT=2.
module tb_horner_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       start_coeff = 0, coeff_reload = 0, sig_empty = 1;
  logic       flush = 0, result_ready = 0;
  logic [4:0] coeff_cnt = 0;
  logic       rst_reg_n, wr_en_coeff, rd_en_signal, rd_en_coeff;
  logic [3:0] coeff_rd_addr;
  logic       LD_signal, LD_coeff, LD_result, redo;
  logic       result_valid, busy, cfg_err;

  logic       start_b = 0, reload_b = 0, empty_b = 1;
  logic       flush_b = 0, ready_b = 1;
  logic [4:0] cnt_b = 0;
  logic       rst_reg_n_b, wr_en_b, rd_sig_b, rd_coeff_b;
  logic [3:0] addr_b;
  logic       ld_sig_b, ld_coeff_b, ld_res_b, redo_b;
  logic       valid_b, busy_b, cfg_err_b;
`ifdef NLA_PERF_CNT_EN
  logic [15:0] samples_done, stall_cycles, sd_b, sc_b;
`endif

  horner_seq_ctrl #(.ADDR_LINES(4), .MUL_LAT(1), .ADD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start_coeff(start_coeff), .coeff_cnt(coeff_cnt),
    .coeff_reload(coeff_reload), .sig_empty(sig_empty),
    .flush(flush), .result_ready(result_ready),
    .rst_reg_n(rst_reg_n), .wr_en_coeff(wr_en_coeff),
    .rd_en_signal(rd_en_signal), .rd_en_coeff(rd_en_coeff),
    .coeff_rd_addr(coeff_rd_addr), .LD_signal(LD_signal),
    .LD_coeff(LD_coeff), .LD_result(LD_result), .redo(redo),
    .result_valid(result_valid), .busy(busy), .cfg_err(cfg_err)
`ifdef NLA_PERF_CNT_EN
    , .samples_done(samples_done), .stall_cycles(stall_cycles)
`endif
  );

  horner_seq_ctrl #(.ADDR_LINES(4), .MUL_LAT(3), .ADD_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .start_coeff(start_b), .coeff_cnt(cnt_b),
    .coeff_reload(reload_b), .sig_empty(empty_b),
    .flush(flush_b), .result_ready(ready_b),
    .rst_reg_n(rst_reg_n_b), .wr_en_coeff(wr_en_b),
    .rd_en_signal(rd_sig_b), .rd_en_coeff(rd_coeff_b),
    .coeff_rd_addr(addr_b), .LD_signal(ld_sig_b),
    .LD_coeff(ld_coeff_b), .LD_result(ld_res_b), .redo(redo_b),
    .result_valid(valid_b), .busy(busy_b), .cfg_err(cfg_err_b)
`ifdef NLA_PERF_CNT_EN
    , .samples_done(sd_b), .stall_cycles(sc_b)
`endif
  );

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call right after step() while in WAIT_X; returns at the
  // negedge of the first result_valid cycle.
  task automatic run_sample(input int deg, input string tag);
    int lexp, ld_at, nf, bad, ea;
    lexp = 1 + (deg + 1) * 4;
    sig_empty = 0;
    @(negedge clk);
    check_eq({tag, "_pop"}, rd_en_signal, 1);
    check_eq({tag, "_redo"}, redo, 1);
    step();
    sig_empty = 1;
    ld_at = -1; nf = 0; bad = 0; ea = deg;
    for (int c = 1; c <= lexp; c++) begin
      @(negedge clk);
      if (rd_en_coeff) begin
        if (coeff_rd_addr !== ea[3:0]) bad++;
        ea--;
        nf++;
      end
      if (rd_en_signal || wr_en_coeff || result_valid) bad++;
      if (LD_result && ld_at < 0) ld_at = c;
      step();
    end
    @(negedge clk);
    check_eq({tag, "_ld_result_at"}, ld_at, lexp);
    check_eq({tag, "_fetches"}, nf, deg + 1);
    check_eq({tag, "_seq_errs"}, bad, 0);
    check_eq({tag, "_valid"}, result_valid, 1);
  endtask

  initial begin
    int pulses, ld_at;
    #2 rst_n = 0;
    #10;
    check_eq("rst_reg_n_in_reset", rst_reg_n, 0);
    check_eq("wr_en_in_reset", wr_en_coeff, 0);
    check_eq("busy_in_reset", busy, 0);
    check_eq("valid_in_reset", result_valid, 0);
    check_eq("addr_in_reset", coeff_rd_addr, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check_eq("rst_reg_n_before_edge", rst_reg_n, 0);
    step();
    @(negedge clk);
    check_eq("rst_reg_n_after_edge", rst_reg_n, 1);
    check_eq("wr_en_idle", wr_en_coeff, 1);

    for (int k = 0; k < 2; k++) begin
      step();
      coeff_cnt = (k == 0) ? 5'd0 : 5'd17;
      start_coeff = 1;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (cfg_err) pulses++;
        step();
      end
      @(negedge clk);
      check_eq("cfg_err_pulses", pulses, 1);
      check_eq("cfg_err_busy", busy, 0);
      check_eq("cfg_err_wr_en", wr_en_coeff, 0);
      step();
      start_coeff = 0;
      @(negedge clk);
      check_eq("cfg_err_still_idle", wr_en_coeff, 1);
    end

    step();
    coeff_cnt = 3;
    start_coeff = 1;
    step();
    start_coeff = 0;
    result_ready = 0;
    run_sample(2, "deg2");
    sig_empty = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      check_eq("stall_valid_held", result_valid, 1);
      check_eq("stall_no_pop", rd_en_signal, 0);
    end
    step();
    result_ready = 1;
    sig_empty = 1;
    @(negedge clk);
    check_eq("stall_last_valid", result_valid, 1);
    step();
    @(negedge clk);
    check_eq("hs_valid_drop", result_valid, 0);
    check_eq("hs_not_busy", busy, 0);
`ifdef NLA_PERF_CNT_EN
    check_eq("stall_cycles", stall_cycles, 5);
    check_eq("samples_done_1", samples_done, 1);
`endif

    step();
    for (int s = 0; s < 3; s++) begin
      run_sample(2, "b2b");
      step();
    end
    @(negedge clk);
    check_eq("b2b_valid_drop", result_valid, 0);
    check_eq("b2b_no_refill", wr_en_coeff, 0);
`ifdef NLA_PERF_CNT_EN
    check_eq("samples_done_4", samples_done, 4);
`endif

    step();
    sig_empty = 0;
    step();
    sig_empty = 1;
    step();
    flush = 1;
    @(negedge clk);
    check_eq("flush_busy_mul_wait", busy, 1);
    step();
    flush = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (LD_result || result_valid || busy) pulses++;
      step();
    end
    check_eq("flush_aborted", pulses, 0);
    run_sample(2, "post_flush");
    step();

    coeff_reload = 1;
    step();
    coeff_reload = 0;
    @(negedge clk);
    check_eq("reload_idle_wr_en", wr_en_coeff, 1);
`ifdef NLA_PERF_CNT_EN
    check_eq("reload_clears_cnt", samples_done, 0);
`endif
    step();
    coeff_cnt = 16;
    start_coeff = 1;
    step();
    start_coeff = 0;
    run_sample(15, "deg15");
    step();
    @(negedge clk);
    check_eq("deg15_done", result_valid, 0);

    step();
    cnt_b = 1;
    start_b = 1;
    step();
    start_b = 0;
    empty_b = 0;
    @(negedge clk);
    check_eq("lat32_pop", rd_sig_b, 1);
    step();
    empty_b = 1;
    ld_at = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ld_res_b && ld_at < 0) ld_at = c;
      step();
    end
    @(negedge clk);
    check_eq("lat32_ld_result_at", ld_at, 8);
    check_eq("lat32_back_wait", busy_b, 0);
    check_eq("lat32_valid_drop", valid_b, 0);
    step();
    reload_b = 1;
    step();
    reload_b = 0;
    @(negedge clk);
    check_eq("lat32_reload_wr_en", wr_en_b, 1);
    check_eq("lat32_reload_idle", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
